// File: rtl/otter_io_pkg.sv
// Shared definitions for the OTTER UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state type.
package otter_io_pkg;

  localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Reset clears pointers and count;
// the head entry is presented combinationally on o_dout.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; only entries between the pointers are ever read, so clearing it buys nothing.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/otter_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the OTTER CPU: TXDATA pushes bytes
// into a FIFO, STATUS reports occupancy/flags, the FSM serialises bytes on TX.
module otter_uart_tx
  import otter_io_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0040
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_t       r_state;
  logic              r_tx;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit_idx;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic              r_overflow;

  logic              w_sel_tx;
  logic              w_sel_status;
  logic              w_wr_tx;
  logic              w_wr_status;
  logic              w_push;
  logic              w_pop;
  logic              w_bit_done;
  logic              w_busy;
  logic              w_full;
  logic              w_empty;
  logic [7:0]        w_dout;
  logic [CNT_W-1:0]  w_count;
  logic [3:0]        w_count_lo;
  logic              w_unused;

  assign w_sel_tx     = (IOBUS_ADDR == BASE_ADDR + UART_TXDATA_OFS);
  assign w_sel_status = (IOBUS_ADDR == BASE_ADDR + UART_STATUS_OFS);
  assign w_wr_tx      = IOBUS_WR && w_sel_tx;
  assign w_wr_status  = IOBUS_WR && w_sel_status;
  assign w_push       = w_wr_tx && !w_full && !RST;
  assign w_bit_done   = (r_baud_cnt == BAUD_LAST);
  assign w_busy       = (r_state != ST_IDLE);
  assign w_count_lo   = 4'(w_count);
  assign w_unused     = ^IOBUS_OUT[31:8];
  assign TX           = r_tx;

  // Pops only ever see the registered empty flag, so a push into an empty FIFO is served one edge later.
  assign w_pop = !RST && !w_empty &&
                 ((r_state == ST_IDLE) || (r_state == ST_STOP && w_bit_done));

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (IOBUS_OUT[7:0]),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    IOBUS_IN = '0;
    if (w_sel_status) begin
      IOBUS_IN[STAT_BUSY]            = w_busy;
      IOBUS_IN[STAT_FULL]            = w_full;
      IOBUS_IN[STAT_EMPTY]           = w_empty;
      IOBUS_IN[STAT_OVF]             = r_overflow;
      IOBUS_IN[STAT_CNT_LSB +: 4]    = w_count_lo;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_baud_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      // A dropped write wins over a same-cycle clear so the loss is never hidden.
      if (w_wr_tx && w_full)  r_overflow <= 1'b1;
      else if (w_wr_status)   r_overflow <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
          r_tx       <= 1'b1;
          if (!w_empty) begin
            r_shift <= w_dout;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= r_shift[0];
            r_state    <= ST_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            if (!w_empty) begin
              r_shift <= w_dout;
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/otter_uart_tx.md
OTTER_UART_TX -- requirements
Module: otter_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 2..65535).
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, 2..64).
REQ-003 Parameter BASE_ADDR, default 32'h1100_0040, byte address of the TXDATA register.
REQ-004 CLK  input  1  single clock, rising-edge active.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 IOBUS_ADDR  input  32  CPU MMIO address.
REQ-007 IOBUS_OUT  input  32  CPU MMIO write data.
REQ-008 IOBUS_WR  input  1  CPU MMIO write strobe, one cycle per write.
REQ-009 IOBUS_IN  output  32  read data returned to the CPU.
REQ-010 TX  output  1  serial line, 8N1, idle high.

Function
REQ-011 Address map: TXDATA = BASE_ADDR, STATUS = BASE_ADDR+4; all other addresses ignored.
REQ-012 IOBUS_WR=1 with IOBUS_ADDR=TXDATA and FIFO not full SHALL push IOBUS_OUT[7:0] at that rising edge; bits [31:8] ignored.
REQ-013 Write to TXDATA while FIFO full SHALL be dropped and set sticky overflow, even if a pop occurs in the same cycle.
REQ-014 Any write to STATUS SHALL clear overflow; simultaneous overflow-set and clear SHALL leave overflow set.
REQ-015 IOBUS_IN SHALL be combinational: STATUS address -> {24'b0, count[3:0], overflow, empty, full, busy}; TXDATA or unmapped -> 32'h0.
REQ-016 count SHALL be FIFO occupancy 0..FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0); busy = FSM not IDLE.
REQ-017 FSM states IDLE, START, DATA, STOP; TX is a registered output.
REQ-018 IDLE: if FIFO non-empty, pop head into shift register, go START, TX<=0 at that edge; else TX stays 1.
REQ-019 START: TX=0 for CLKS_PER_BIT cycles, then DATA.
REQ-020 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index, go STOP after bit 7.
REQ-021 STOP: TX=1 for CLKS_PER_BIT cycles; on final cycle, if FIFO non-empty, pop and go directly START (no idle gap), else IDLE.
REQ-022 Latency: write into empty FIFO with FSM IDLE at edge k -> TX falls at edge k+1; frame length exactly 10*CLKS_PER_BIT cycles.
REQ-023 Simultaneous push and pop with FIFO neither full nor empty SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 Push to empty FIFO and IDLE pop SHALL NOT occur in the same cycle (pop sees registered empty).
REQ-025 Baud counter SHALL be wide enough for CLKS_PER_BIT-1 and reset to 0 on every state/bit change.

Reset
REQ-026 RST=1 at a rising edge SHALL force: FSM IDLE, TX=1, FIFO empty (count 0), overflow 0, counters 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (TX=1 next edge) and discard FIFO contents.
REQ-028 Writes coincident with RST=1 SHALL be ignored.

Structure
REQ-029 Package otter_io_pkg SHALL hold UART address offsets, STATUS bit indices, and the FSM state enum.
REQ-030 FIFO SHALL be a separate sub-module sync_fifo (parameterised WIDTH, DEPTH; push, pop, dout, count, full, empty).
REQ-031 No other sub-modules; no latches; single always_ff domain on CLK.

Verification
REQ-032 Reset: hold RST 3 cycles -> TX=1, STATUS read = 32'h0000_0004.
REQ-033 Single byte: write 32'h0000_00A5 to 0x1100_0040 at edge k -> TX: 0 for cycles k+1..k+4, then bits 1,0,1,0,0,1,0,1 x4 cycles each, then 1 x4; busy drops at k+41.
REQ-034 Back-to-back: write 0x55 then 0x0F on consecutive cycles -> two frames, 80 cycles total, no idle gap, STATUS count 1 during first frame.
REQ-035 Overflow: 9 writes in 9 consecutive cycles while IDLE -> first byte popped, 8 queued, 0 dropped; 10 writes -> 9th... 10th dropped, STATUS bit3=1 and full=1; write to 0x1100_0044 -> bit3=0.
REQ-036 Reset mid-frame: assert RST during DATA bit 3 of 0xFF with 2 queued -> TX=1 next edge, count 0, no further frames.
REQ-037 Unmapped: write 0x1100_0048 -> no FIFO change; read returns 32'h0.
